ram_port_arbiter: RTL and testbench

// Shares the single-port command interface of the SPI-slave RAM between NREQ requesters (SPI slave, debug/DMA host).

---
 rtl/ram_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single-port command interface of the SPI-slave RAM between
//   NREQ requesters. Each whole read/write transaction is expanded into the
//   RAM's two-word command sequence:
//     write: {2'b00, addr} then {2'b01, wdata}
//     read : {2'b10, addr} then {2'b11, 0}, then wait for ram_tx_valid
//   Requesters are served round-robin. All outputs are registered.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req/we/addr/wdata     per-requester transaction (addr/wdata packed,
//                         requester i at [i*ADDR_SIZE +: ADDR_SIZE])
//   gnt                   one-hot owner of the current transaction
//   done                  one-cycle completion pulse to the owner
//   err                   pulses with done when a read timed out
//   rdata                 read data, valid while done is high for a read
//   ram_din/ram_rx_valid  command word to the RAM and its strobe
//   ram_dout/ram_tx_valid read data from the RAM and its strobe
//   state_dbg             current FSM state (IDLE=0 ADDR=1 DATA=2 WAIT=3 DONE=4)
//
// Requester handshake: a requester raises req with stable we/addr/wdata and
// holds all of them until it sees its done bit high for one cycle. req must
// be low in the cycle after done, otherwise it is taken as a new request.
// gnt marks the owner from the first command cycle until done has been shown.

module ram_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ*ADDR_SIZE-1:0] addr,
  input  logic [NREQ*ADDR_SIZE-1:0] wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic                      err,
  output logic [ADDR_SIZE-1:0]      rdata,
  output logic [ADDR_SIZE+1:0]      ram_din,
  output logic                      ram_rx_valid,
  input  logic [ADDR_SIZE-1:0]      ram_dout,
  input  logic                      ram_tx_valid,
  output logic [2:0]                state_dbg
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic                 err_q, err_d;
  logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
  logic [ADDR_SIZE+1:0] din_q, din_d;
  logic                 rxv_q, rxv_d;
  logic [IDX_W-1:0]     rr_q, rr_d;     // last winner
  logic [IDX_W-1:0]     win_q, win_d;   // current owner
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Round-robin pick: scan from the requester after the last winner.
  logic             found;
  logic [IDX_W-1:0] pick;
  int               cand;

  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_q) + k) % NREQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    din_d   = din_q;
    rxv_d   = 1'b0;
    rr_d    = rr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (found) begin
          win_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          we_d    = we[pick];
          addr_d  = addr[pick*ADDR_SIZE +: ADDR_SIZE];
          wdata_d = wdata[pick*ADDR_SIZE +: ADDR_SIZE];
          // First command word goes out in the same edge that enters ADDR.
          rxv_d   = 1'b1;
          din_d   = {(we[pick] ? 2'b00 : 2'b10), addr[pick*ADDR_SIZE +: ADDR_SIZE]};
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        rxv_d   = 1'b1;
        din_d   = {(we_q ? 2'b01 : 2'b11), (we_q ? wdata_q : '0)};
        state_d = S_DATA;
      end
      S_DATA: begin
        if (we_q) begin
          done_d  = gnt_q;
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A late tx_valid on the timeout cycle still counts as a good read.
        if (ram_tx_valid) begin
          rdata_d = ram_dout;
          done_d  = gnt_q;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        rr_d    = win_q;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      din_q   <= '0;
      rxv_q   <= 1'b0;
      rr_q    <= IDX_W'(NREQ - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      din_q   <= din_d;
      rxv_q   <= rxv_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign ram_din      = din_q;
  assign ram_rx_valid = rxv_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 8;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    we = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*AW-1:0] wdata = '0;
  logic [NREQ-1:0]    gnt, done;
  logic               err;
  logic [AW-1:0]      rdata;
  logic [AW+1:0]      ram_din;
  logic               ram_rx_valid;
  logic [AW-1:0]      ram_dout;
  logic               ram_tx_valid;
  logic [2:0]         state_dbg;

  // RAM responder and stray-strobe sources
  logic          rsp_en = 1'b1;
  logic          rsp_arm = 1'b0;
  logic          rsp_tx = 1'b0;
  logic [AW-1:0] rsp_dout = '0;
  logic          stray_tx = 1'b0;
  logic [AW-1:0] stray_dout = '0;
  logic [AW-1:0] pend_addr = '0;
  logic [AW-1:0] ram_mem [256];
  logic [AW-1:0] tb_mem [256];
  logic [AW-1:0] exp_rdata_last = '0;

  assign ram_tx_valid = rsp_tx | stray_tx;
  assign ram_dout     = rsp_tx ? rsp_dout : stray_dout;

  ram_port_arbiter #(.NREQ(NREQ), .ADDR_SIZE(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .ram_din(ram_din),
    .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  // exp_q entry: [11:10] done vector, [9] err, [8] is_read, [7:0] rdata
  logic [11:0] exp_q[$];
  logic [9:0]  cmd_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int gnt_viol = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      tb_mem[i]  = '0;
    end
  end

  // Monitor + RAM model, sampled on the falling edge
  always @(negedge clk) begin
    logic [11:0] e;
    logic [9:0]  c;
    if (rsp_tx) rsp_tx = 1'b0;
    if (rsp_arm) begin
      rsp_tx   = 1'b1;
      rsp_dout = ram_mem[pend_addr];
      rsp_arm  = 1'b0;
    end
    if (rst_n) begin
      if ($countones(gnt) > 1) gnt_viol++;
      if ((done & ~gnt) != '0) gnt_viol++;
      if (ram_rx_valid) begin
        if (cmd_q.size() == 0) check("ram_din_extra", {22'd0, ram_din}, 32'h0);
        else begin
          c = cmd_q.pop_front();
          check("ram_din", {22'd0, ram_din}, {22'd0, c});
        end
        case (ram_din[9:8])
          2'b00, 2'b10: pend_addr = ram_din[7:0];
          2'b01: ram_mem[pend_addr] = ram_din[7:0];
          default: if (rsp_en) rsp_arm = 1'b1;
        endcase
      end
      if (done != '0) begin
        if (exp_q.size() == 0) check("done_extra", {30'd0, done}, 32'h0);
        else begin
          e = exp_q.pop_front();
          check("done_vec", {30'd0, done}, {30'd0, e[11:10]});
          check("err", {31'd0, err}, {31'd0, e[9]});
          if (e[8]) check("rdata", {24'd0, rdata}, {24'd0, e[7:0]});
        end
      end else if (err) begin
        check("err_stray", {31'd0, err}, 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input int id, input logic w, input logic [AW-1:0] a,
                         input logic [AW-1:0] d, input bit respond, input bit stray,
                         input int exp_lat);
    int lat;
    logic [AW-1:0] er;
    logic e_err;
    @(negedge clk);
    req[id] = 1'b1;
    we[id] = w;
    addr[id*AW +: AW] = a;
    wdata[id*AW +: AW] = d;
    rsp_en = respond;
    cmd_q.push_back({(w ? 2'b00 : 2'b10), a});
    cmd_q.push_back({(w ? 2'b01 : 2'b11), (w ? d : 8'h00)});
    e_err = !w && !respond;
    if (w) tb_mem[a] = d;
    else if (respond) exp_rdata_last = tb_mem[a];
    er = exp_rdata_last;
    exp_q.push_back({2'(1 << id), e_err, !w, er});
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (stray && i == 1) begin
        stray_dout = 8'h5A;
        stray_tx = 1'b1;
      end
      if (i == 2) stray_tx = 1'b0;
      if (done[id]) begin
        lat = i;
        break;
      end
    end
    stray_tx = 1'b0;
    check("latency", lat, exp_lat);
    req[id] = 1'b0;
    @(posedge clk);
    rsp_en = 1'b1;
  endtask

  // Both requesters hold write requests; expect alternating service.
  task automatic run_both(input int n, input int start,
                          input logic [AW-1:0] a0, input logic [AW-1:0] d0,
                          input logic [AW-1:0] a1, input logic [AW-1:0] d1);
    int cnt;
    int own;
    @(negedge clk);
    req = 2'b11;
    we = 2'b11;
    addr = {a1, a0};
    wdata = {d1, d0};
    for (int k = 0; k < n; k++) begin
      own = (start + k) % 2;
      cmd_q.push_back({2'b00, (own == 0) ? a0 : a1});
      cmd_q.push_back({2'b01, (own == 0) ? d0 : d1});
      exp_q.push_back({2'(1 << own), 1'b0, 1'b0, exp_rdata_last});
    end
    tb_mem[a0] = d0;
    tb_mem[a1] = d1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done != '0) cnt++;
      if (cnt == n) break;
    end
    req = '0;
    check("pair_dones", cnt, n);
    @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {30'd0, gnt}, 32'h0);
    check({tag, "_done"}, {30'd0, done}, 32'h0);
    check({tag, "_err"}, {31'd0, err}, 32'h0);
    check({tag, "_rxv"}, {31'd0, ram_rx_valid}, 32'h0);
    check({tag, "_din"}, {22'd0, ram_din}, 32'h0);
    check({tag, "_rdata"}, {24'd0, rdata}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a, d;
    logic w;
    int id;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", {29'd0, state_dbg}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: write from requester 0
    run_txn(0, 1'b1, 8'h3C, 8'hA5, 1'b1, 1'b0, 3);
    // 2: read from requester 1 of the same location
    run_txn(1, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 4);
    // 3: both held, four transactions alternating 0,1,0,1
    run_both(4, 0, 8'h10, 8'h11, 8'h20, 8'h22);
    // random single transactions, reads use a nominal RAM
    for (int n = 0; n < 8; n++) begin
      id = $urandom_range(0, 1);
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      run_txn(id, w, a, d, 1'b1, 1'b0, w ? 3 : 4);
    end
    // 6: stray tx_valid in IDLE, then during ADDR of a read
    @(negedge clk);
    stray_dout = 8'h77;
    stray_tx = 1'b1;
    @(negedge clk);
    stray_tx = 1'b0;
    @(negedge clk);
    check("stray_idle_rdata", {24'd0, rdata}, {24'd0, exp_rdata_last});
    check("stray_idle_done", {30'd0, done}, 32'h0);
    run_txn(0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 4);
    // 4: read timeout, rdata must keep its value
    run_txn(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 3 + TIMEOUT);
    // 5: reset during DATA of a read by requester 1
    @(negedge clk);
    req[1] = 1'b1;
    we[1] = 1'b0;
    addr[AW +: AW] = 8'h11;
    cmd_q.push_back({2'b10, 8'h11});
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_state", {29'd0, state_dbg}, 32'h2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    req = '0;
    exp_rdata_last = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // requester 0 must win first after reset
    run_both(2, 0, 8'h30, 8'h33, 8'h40, 8'h44);

    repeat (4) @(negedge clk);
    check("cmd_q_left", cmd_q.size(), 0);
    check("exp_q_left", exp_q.size(), 0);
    check("gnt_onehot", gnt_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
